execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter RF_ADDR_WIDTH, default 5, register-file address width.
REQ-003 SHALL have port i_CLK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port i_RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_SrcAE, i_SrcBE, i_SignImmE  input  DATA_WIDTH  operands and immediate from the decode-to-execute register.
REQ-006 SHALL have ports i_RtE, i_RdE  input  RF_ADDR_WIDTH  destination candidates.
REQ-007 SHALL have ports i_ALUControlE  input  3, i_ALUSrcE  input  1, i_RegDstE  input  1  control fields.
REQ-008 SHALL have ports i_ForwardAE, i_ForwardBE  input  2  forwarding selects: 00 register, 01 i_ResultW, 10 i_ALUOutM.
REQ-009 SHALL have ports i_ALUOutM, i_ResultW  input  DATA_WIDTH  forwarded values.
REQ-010 SHALL have ports i_MDStartE  input  1 (start multiply/divide), i_MDOpE  input  1 (0 MULTU, 1 DIVU), i_MDReadE  input  2 (00 none, 01 MFHI, 10 MFLO).
REQ-011 SHALL have ports o_ALUOutE, o_WriteDataE  output  DATA_WIDTH; o_WriteRegE  output  RF_ADDR_WIDTH; o_MDBusy, o_MDStall  output  1.

Function
REQ-012 SHALL select forwarded A/B per REQ-008; encoding 11 SHALL behave as 00.
REQ-013 SHALL drive o_WriteDataE with forwarded B; ALU B operand = i_SignImmE when i_ALUSrcE=1, else forwarded B.
REQ-014 SHALL compute ALU combinationally: 010 add, 110 sub, 000 AND, 001 OR, 111 signed SLT (result 1 or 0); 011/100/101 yield 0; add/sub wrap modulo 2^DATA_WIDTH.
REQ-015 SHALL set o_WriteRegE = i_RdE when i_RegDstE=1, else i_RtE.
REQ-016 SHALL override o_ALUOutE with HI when i_MDReadE=01 and LO when 10, and with the ALU result otherwise; 11 SHALL be treated as 00.
REQ-017 SHALL implement FSM IDLE/BUSY; in IDLE with i_MDStartE=1 latch forwarded A, B and i_MDOpE, clear counter, go BUSY.
REQ-018 SHALL in BUSY perform one shift-add (MULTU) or restoring-subtract (DIVU) iteration per cycle, unsigned, 32 iterations.
REQ-019 SHALL write HI/LO on the 32nd BUSY edge and return to IDLE; MULTU: HI:LO = 64-bit product; DIVU: LO = quotient, HI = remainder.
REQ-020 SHALL for DIVU with divisor 0 produce LO = all ones, HI = dividend.
REQ-021 SHALL drive o_MDBusy = (state==BUSY); after the accepting edge E0, busy for cycles E0..E32, low after E32.
REQ-022 SHALL drive o_MDStall = o_MDBusy AND (i_MDStartE OR i_MDReadE!=00), combinationally.
REQ-023 SHALL ignore i_MDStartE while BUSY; HI/LO SHALL hold their old values until the completing edge.
REQ-024 SHALL allow start on the same edge BUSY completes only if sampled in IDLE (i.e. the next cycle); no back-to-back overlap.

Reset
REQ-025 SHALL on i_RST low asynchronously force IDLE, counter 0, HI=0, LO=0, operand latches 0, o_MDBusy=0; an in-flight operation SHALL be aborted with no HI/LO update.
REQ-026 SHALL keep combinational outputs a function of inputs and HI/LO during reset (o_ALUOutE = 0 for MFHI/MFLO).

Structure
REQ-027 SHALL take ALU control codes, forward-select codes, MD op/read codes and FSM state encoding from shared package mips_pkg.
REQ-028 SHALL place the iterative unit in one sub-module muldiv_unit; ALU, forwarding and RegDst muxes SHALL stay in execute_stage.

Verification
REQ-029 SHALL cover: SrcA=5, SrcB=7, ALUControl=111, ForwardAE=10, ALUOutM=9 -> o_ALUOutE=0 (SLT of 9<7 false).
REQ-030 SHALL cover: MULTU A=0xFFFFFFFF, B=2 -> busy 32 cycles, then HI=1, LO=0xFFFFFFFE; MFLO returns 0xFFFFFFFE.
REQ-031 SHALL cover: DIVU 100/7 -> LO=14, HI=2; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
REQ-032 SHALL cover: MFHI issued at busy cycle 10 -> o_MDStall=1 until busy drops, then the correct HI is returned.
REQ-033 SHALL cover: reset asserted at busy cycle 16 of MULTU -> busy=0 immediately, HI=LO=0, next start completes correctly.
REQ-034 SHALL cover: second start asserted while BUSY -> ignored, o_MDStall=1, first result intact.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU control, forwarding selects,
// multiply/divide opcodes and the multiply/divide sequencer state.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUOUTM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MD_MULTU = 1'b0,
    MD_DIVU  = 1'b1
  } md_op_e;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MFHI = 2'b01,
    MD_MFLO = 2'b10
  } md_read_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// HI/LO change only on the final iteration edge.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  md_state_e             state_reg, state_next;
  logic [CNT_W-1:0]      count_reg;
  logic                  op_reg;
  logic [DATA_WIDTH-1:0] work_hi_reg, work_lo_reg, operand_reg;
  logic [DATA_WIDTH-1:0] hi_reg, lo_reg;
  logic [DATA_WIDTH-1:0] step_hi, step_lo, div_diff;
  logic [DATA_WIDTH:0]   mul_sum, div_shift;
  logic                  last_step;

  assign last_step = (count_reg == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= MD_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: if (start)     state_next = MD_BUSY;
      MD_BUSY: if (last_step) state_next = MD_IDLE;
      default:                state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == MD_BUSY);
  end

  // Multiply: {work_hi, work_lo} is the partial product with the multiplier in the low half.
  // Divide: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, operand_reg} : '0);
    div_shift = {work_hi_reg, work_lo_reg[DATA_WIDTH-1]};
    div_diff  = div_shift[DATA_WIDTH-1:0] - operand_reg;
    step_hi   = div_shift[DATA_WIDTH-1:0];
    step_lo   = {work_lo_reg[DATA_WIDTH-2:0], 1'b0};
    if (op_reg == MD_MULTU) begin
      step_hi = mul_sum[DATA_WIDTH:1];
      step_lo = {mul_sum[0], work_lo_reg[DATA_WIDTH-1:1]};
    end else if (div_shift >= {1'b0, operand_reg}) begin
      step_hi = div_diff;
      step_lo = {work_lo_reg[DATA_WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= '0;
      op_reg      <= 1'b0;
      work_hi_reg <= '0;
      work_lo_reg <= '0;
      operand_reg <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else if (state_reg == MD_IDLE) begin
      if (start) begin
        op_reg      <= op;
        work_hi_reg <= '0;
        work_lo_reg <= a;
        operand_reg <= b;
        count_reg   <= '0;
      end
    end else begin
      work_hi_reg <= step_hi;
      work_lo_reg <= step_lo;
      count_reg   <= count_reg + CNT_W'(1);
      if (last_step) begin
        hi_reg <= step_hi;
        lo_reg <= step_lo;
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: operand forwarding, ALU, destination select and
// HI/LO reads from the iterative multiply/divide unit.
module execute_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [DATA_WIDTH-1:0]    i_SrcAE,
  input  logic [DATA_WIDTH-1:0]    i_SrcBE,
  input  logic [DATA_WIDTH-1:0]    i_SignImmE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RdE,
  input  logic [2:0]               i_ALUControlE,
  input  logic                     i_ALUSrcE,
  input  logic                     i_RegDstE,
  input  logic [1:0]               i_ForwardAE,
  input  logic [1:0]               i_ForwardBE,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_ResultW,
  input  logic                     i_MDStartE,
  input  logic                     i_MDOpE,
  input  logic [1:0]               i_MDReadE,
  output logic [DATA_WIDTH-1:0]    o_ALUOutE,
  output logic [DATA_WIDTH-1:0]    o_WriteDataE,
  output logic [RF_ADDR_WIDTH-1:0] o_WriteRegE,
  output logic                     o_MDBusy,
  output logic                     o_MDStall
);

  logic [DATA_WIDTH-1:0] src_a, src_b, alu_b, alu_result, hi, lo;
  logic                  md_busy;

  always_comb begin
    case (i_ForwardAE)
      FWD_RESULTW: src_a = i_ResultW;
      FWD_ALUOUTM: src_a = i_ALUOutM;
      default:     src_a = i_SrcAE;
    endcase
    case (i_ForwardBE)
      FWD_RESULTW: src_b = i_ResultW;
      FWD_ALUOUTM: src_b = i_ALUOutM;
      default:     src_b = i_SrcBE;
    endcase
  end

  assign alu_b        = i_ALUSrcE ? i_SignImmE : src_b;
  assign o_WriteDataE = src_b;
  assign o_WriteRegE  = i_RegDstE ? i_RdE : i_RtE;

  always_comb begin
    case (i_ALUControlE)
      ALU_ADD: alu_result = src_a + alu_b;
      ALU_SUB: alu_result = src_a - alu_b;
      ALU_AND: alu_result = src_a & alu_b;
      ALU_OR:  alu_result = src_a | alu_b;
      ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    case (i_MDReadE)
      MD_MFHI: o_ALUOutE = hi;
      MD_MFLO: o_ALUOutE = lo;
      default: o_ALUOutE = alu_result;
    endcase
  end

  muldiv_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk   (i_CLK),
    .rst_n (i_RST),
    .start (i_MDStartE),
    .op    (i_MDOpE),
    .a     (src_a),
    .b     (src_b),
    .busy  (md_busy),
    .hi    (hi),
    .lo    (lo)
  );

  assign o_MDBusy  = md_busy;
  assign o_MDStall = md_busy & (i_MDStartE | (i_MDReadE != MD_NONE));

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_execute_stage;

  localparam int F_ALU   = 0;
  localparam int F_WD    = 1;
  localparam int F_WR    = 2;
  localparam int F_BUSY  = 3;
  localparam int F_STALL = 4;

  typedef struct {
    string       name;
    int          field;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src_a, src_b, imm, alu_out_m, result_w;
  logic [4:0]  rt, rd;
  logic [2:0]  alu_ctrl;
  logic        alu_src, reg_dst;
  logic [1:0]  fwd_a, fwd_b;
  logic        md_start, md_op;
  logic [1:0]  md_read;
  logic [31:0] alu_out, write_data;
  logic [4:0]  write_reg;
  logic        md_busy, md_stall;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  execute_stage #(
    .DATA_WIDTH(32),
    .RF_ADDR_WIDTH(5)
  ) dut (
    .i_CLK         (clk),
    .i_RST         (rst_n),
    .i_SrcAE       (src_a),
    .i_SrcBE       (src_b),
    .i_SignImmE    (imm),
    .i_RtE         (rt),
    .i_RdE         (rd),
    .i_ALUControlE (alu_ctrl),
    .i_ALUSrcE     (alu_src),
    .i_RegDstE     (reg_dst),
    .i_ForwardAE   (fwd_a),
    .i_ForwardBE   (fwd_b),
    .i_ALUOutM     (alu_out_m),
    .i_ResultW     (result_w),
    .i_MDStartE    (md_start),
    .i_MDOpE       (md_op),
    .i_MDReadE     (md_read),
    .o_ALUOutE     (alu_out),
    .o_WriteDataE  (write_data),
    .o_WriteRegE   (write_reg),
    .o_MDBusy      (md_busy),
    .o_MDStall     (md_stall)
  );

  // Monitor: every expectation queued during a cycle is checked on that cycle's falling edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.field)
        F_ALU:   act = alu_out;
        F_WD:    act = write_data;
        F_WR:    act = {27'd0, write_reg};
        F_BUSY:  act = {31'd0, md_busy};
        default: act = {31'd0, md_stall};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, act, e.val);
      end else begin
        $display("ok   %s = %h", e.name, act);
      end
    end
  end

  function automatic void push(input string n, input int f, input logic [31:0] v);
    exp_t e;
    e.name  = n;
    e.field = f;
    e.val   = v;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_vec(input string n, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctrl, input logic [1:0] fa, input logic [1:0] fb,
                         input logic asrc, input logic [31:0] im,
                         input logic [31:0] exp_alu, input logic [31:0] exp_wd);
    src_a = a; src_b = b; alu_ctrl = ctrl; fwd_a = fa; fwd_b = fb;
    alu_src = asrc; imm = im;
    push({n, "_alu"}, F_ALU, exp_alu);
    push({n, "_wd"}, F_WD, exp_wd);
    tick();
  endtask

  // One full multiply/divide: optional read from busy cycle read_at onward, optional
  // extra start at cycle restart_at, then HI/LO read back once the unit is idle.
  task automatic md_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input int read_at, input logic [1:0] rsel,
                        input logic [31:0] old_val, input int restart_at,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    src_a = a; src_b = b; fwd_a = 2'b00; fwd_b = 2'b00; alu_src = 1'b0;
    md_op = op; md_read = 2'b00; md_start = 1'b1;
    push({tag, "_idle_busy"}, F_BUSY, 32'd0);
    push({tag, "_idle_stall"}, F_STALL, 32'd0);
    tick();
    md_start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      md_read  = (read_at >= 0 && c >= read_at) ? rsel : 2'b00;
      md_start = (c == restart_at);
      if (c == restart_at) begin
        src_a = 32'hDEAD_BEEF; src_b = 32'd1; md_op = ~op;
      end
      push($sformatf("%s_busy_c%0d", tag, c), F_BUSY, 32'd1);
      push($sformatf("%s_stall_c%0d", tag, c), F_STALL,
           (md_start || md_read != 2'b00) ? 32'd1 : 32'd0);
      if (md_read != 2'b00) push($sformatf("%s_old_c%0d", tag, c), F_ALU, old_val);
      tick();
    end
    md_start = 1'b0;
    push({tag, "_done_busy"}, F_BUSY, 32'd0);
    push({tag, "_done_stall"}, F_STALL, 32'd0);
    if (md_read == 2'b01) push({tag, "_done_mfhi"}, F_ALU, exp_hi);
    if (md_read == 2'b10) push({tag, "_done_mflo"}, F_ALU, exp_lo);
    tick();
    md_read = 2'b01;
    push({tag, "_hi"}, F_ALU, exp_hi);
    tick();
    md_read = 2'b10;
    push({tag, "_lo"}, F_ALU, exp_lo);
    tick();
    md_read = 2'b00;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    src_a = '0; src_b = '0; imm = '0; alu_out_m = 32'd9; result_w = 32'd3;
    rt = 5'd20; rd = 5'd10; alu_ctrl = 3'b010; alu_src = 1'b0; reg_dst = 1'b0;
    fwd_a = 2'b00; fwd_b = 2'b00; md_op = 1'b0;

    // Reset state: idle, no stall even with start/read asserted, HI/LO read as zero
    md_start = 1'b1; md_read = 2'b01;
    push("rst_busy", F_BUSY, 32'd0);
    push("rst_stall", F_STALL, 32'd0);
    push("rst_mfhi", F_ALU, 32'd0);
    tick();
    md_read = 2'b10;
    push("rst_mflo", F_ALU, 32'd0);
    tick();
    rst_n = 1'b1; md_start = 1'b0; md_read = 2'b00;
    tick();

    alu_vec("slt_fwd_m",   32'd5, 32'd7, 3'b111, 2'b10, 2'b00, 1'b0, 32'd0, 32'd0, 32'd7);
    alu_vec("add",         32'd5, 32'd7, 3'b010, 2'b00, 2'b00, 1'b0, 32'd0, 32'd12, 32'd7);
    alu_vec("sub",         32'd5, 32'd7, 3'b110, 2'b00, 2'b00, 1'b0, 32'd0, 32'hFFFF_FFFE, 32'd7);
    alu_vec("and",         32'hF0F0, 32'hFF00, 3'b000, 2'b00, 2'b00, 1'b0, 32'd0, 32'hF000, 32'hFF00);
    alu_vec("or",          32'hF0F0, 32'hFF00, 3'b001, 2'b00, 2'b00, 1'b0, 32'd0, 32'hFFF0, 32'hFF00);
    alu_vec("slt_neg",     32'hFFFF_FFFF, 32'd1, 3'b111, 2'b00, 2'b00, 1'b0, 32'd0, 32'd1, 32'd1);
    alu_vec("slt_pos",     32'd1, 32'hFFFF_FFFF, 3'b111, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF);
    alu_vec("op_011",      32'd5, 32'd7, 3'b011, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 32'd7);
    alu_vec("op_100",      32'd5, 32'd7, 3'b100, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 32'd7);
    alu_vec("op_101",      32'd5, 32'd7, 3'b101, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 32'd7);
    alu_vec("add_imm",     32'd5, 32'd7, 3'b010, 2'b00, 2'b00, 1'b1, 32'd100, 32'd105, 32'd7);
    alu_vec("fwd_b_w",     32'd5, 32'd7, 3'b010, 2'b00, 2'b01, 1'b0, 32'd0, 32'd8, 32'd3);
    alu_vec("fwd_b_m_imm", 32'd5, 32'd7, 3'b010, 2'b00, 2'b10, 1'b1, 32'd1, 32'd6, 32'd9);
    alu_vec("fwd_a_w_sub", 32'd5, 32'd7, 3'b110, 2'b01, 2'b00, 1'b0, 32'd0, 32'hFFFF_FFFC, 32'd7);
    alu_vec("fwd_11",      32'd5, 32'd7, 3'b010, 2'b11, 2'b11, 1'b0, 32'd0, 32'd12, 32'd7);
    alu_vec("add_wrap",    32'hFFFF_FFFF, 32'd1, 3'b010, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 32'd1);

    // Destination select and the unused read code 11
    fwd_a = 2'b00; fwd_b = 2'b00; alu_src = 1'b0;
    src_a = 32'd5; src_b = 32'd7; alu_ctrl = 3'b010;
    reg_dst = 1'b1;
    push("regdst_rd", F_WR, 32'd10);
    tick();
    reg_dst = 1'b0; md_read = 2'b11;
    push("regdst_rt", F_WR, 32'd20);
    push("mdread_11", F_ALU, 32'd12);
    push("mdread_11_stall", F_STALL, 32'd0);
    tick();
    md_read = 2'b00;

    md_run("multu_max", 32'hFFFF_FFFF, 32'd2, 1'b0, -1, 2'b00, 32'd0, -1, 32'd1, 32'hFFFF_FFFE);
    md_run("divu_100_7", 32'd100, 32'd7, 1'b1, 10, 2'b01, 32'd1, -1, 32'd2, 32'd14);
    md_run("divu_5_0", 32'd5, 32'd0, 1'b1, 3, 2'b10, 32'd14, -1, 32'd5, 32'hFFFF_FFFF);
    md_run("multu_late_start", 32'd3, 32'd5, 1'b0, -1, 2'b00, 32'd0, 31, 32'd0, 32'd15);
    md_run("divu_restart", 32'd200, 32'd9, 1'b1, -1, 2'b00, 32'd0, 5, 32'd2, 32'd22);

    // Abort a multiply at busy cycle 16 with reset, then run a clean one
    src_a = 32'hFFFF_FFFF; src_b = 32'd2; md_op = 1'b0; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    repeat (16) tick();
    checks++;
    if (md_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_busy got %b want 1", md_busy);
    end else begin
      $display("ok   abort_pre_busy = %b", md_busy);
    end
    rst_n = 1'b0; md_read = 2'b01;
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_async_busy got %b want 0", md_busy);
    end else begin
      $display("ok   abort_async_busy = %b", md_busy);
    end
    checks++;
    if (alu_out !== 32'd0) begin
      errors++;
      $display("FAIL abort_async_hi got %h want 0", alu_out);
    end else begin
      $display("ok   abort_async_hi = %h", alu_out);
    end
    push("abort_busy", F_BUSY, 32'd0);
    push("abort_stall", F_STALL, 32'd0);
    push("abort_hi", F_ALU, 32'd0);
    tick();
    md_read = 2'b10;
    push("abort_lo", F_ALU, 32'd0);
    push("abort_busy2", F_BUSY, 32'd0);
    tick();
    rst_n = 1'b1; md_read = 2'b00;
    tick();
    md_run("post_reset", 32'd7, 32'd6, 1'b0, -1, 2'b00, 32'd0, -1, 32'd0, 32'd42);

    tick();
    @(negedge clk);
    #1;
    if (errors == 0 && checks >= 12) $display("PASS");
    else $display("FAIL summary");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
